// File: rtl/johnson_monitor.sv
// Monitors a 4-bit Johnson counter: decodes each sampled code, tracks sequence
// lock with a HUNT/LOCKED FSM, and counts illegal/out-of-sequence samples.
module johnson_monitor #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       code,
  input  logic             clr_err,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [2:0]       LOCK_RUN = 3'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q, state_d;
  logic [2:0]       run_q, run_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             legal;
  logic [2:0]       dec;
  logic             err_ev;

  always_comb begin
    legal = 1'b1;
    dec   = 3'd0;
    case (code)
      4'b0000: dec = 3'd0;
      4'b1000: dec = 3'd1;
      4'b1100: dec = 3'd2;
      4'b1110: dec = 3'd3;
      4'b1111: dec = 3'd4;
      4'b0111: dec = 3'd5;
      4'b0011: dec = 3'd6;
      4'b0001: dec = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;
    if (en) begin
      if (!legal) begin
        code_err_d  = 1'b1;
        run_d       = 3'd0;
        state_d     = HUNT;
        idx_valid_d = 1'b0;
      end else begin
        idx_d       = dec;
        idx_valid_d = 1'b1;
        exp_d       = dec + 3'd1;
        if (state_q == LOCKED) begin
          if (dec != exp_q) begin
            seq_err_d = 1'b1;
            state_d   = HUNT;
            run_d     = 3'd1;
          end
        end else begin
          // A fresh run starts at 1 from any legal sample; only a run > 0 can extend.
          if (dec == exp_q && run_q != 3'd0) run_d = run_q + 3'd1;
          else                               run_d = 3'd1;
          if (run_d >= LOCK_RUN) state_d = LOCKED;
        end
      end
    end
  end

  assign err_ev = code_err_d | seq_err_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err)                            err_cnt_d = ERR_W'(err_ev);
    else if (err_ev && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      run_q       <= 3'd0;
      exp_q       <= 3'd0;
      idx_q       <= 3'd0;
      idx_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = (state_q == LOCKED);
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Scoreboard bench for johnson_monitor: two instances (default and LOCK_CNT=3/ERR_W=2)
// share one stimulus stream and are checked against a rule-level reference model.
module tb_johnson_monitor;

  localparam int W = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] code;
  logic       clr_err;

  logic [2:0] idx0, idx1;
  logic       idx_valid0, idx_valid1, locked0, locked1;
  logic       code_err0, code_err1, seq_err0, seq_err1;
  logic [7:0] err_cnt0;
  logic [1:0] err_cnt1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always #5 clk = ~clk;

  johnson_monitor #(.LOCK_CNT(2), .ERR_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .code(code), .clr_err(clr_err),
    .idx(idx0), .idx_valid(idx_valid0), .locked(locked0),
    .code_err(code_err0), .seq_err(seq_err0), .err_cnt(err_cnt0)
  );

  johnson_monitor #(.LOCK_CNT(3), .ERR_W(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .code(code), .clr_err(clr_err),
    .idx(idx1), .idx_valid(idx_valid1), .locked(locked1),
    .code_err(code_err1), .seq_err(seq_err1), .err_cnt(err_cnt1)
  );

  // Reference model: legal code table, then the lock/error rules on integers.
  logic [3:0] seq_tab[8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] bad_tab[8] = '{4'b0010, 4'b0100, 4'b0101, 4'b0110,
                             4'b1001, 4'b1010, 4'b1011, 4'b1101};
  int lock_need[2] = '{2, 3};
  int err_max[2]   = '{255, 3};
  int m_run[2], m_exp[2], m_idx[2], m_err[2];
  bit m_lock[2], m_valid[2], m_cerr[2], m_serr[2];

  function automatic int lookup(input logic [3:0] c);
    for (int k = 0; k < 8; k++) if (seq_tab[k] == c) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] pack_model(input int i);
    return {3'(m_idx[i]), m_valid[i], m_lock[i], m_cerr[i], m_serr[i], 8'(m_err[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_exp[i] = 0; m_idx[i] = 0; m_err[i] = 0;
      m_lock[i] = 0; m_valid[i] = 0; m_cerr[i] = 0; m_serr[i] = 0;
    end
  endtask

  task automatic model_step(input logic e, input logic [3:0] c, input logic clr);
    int k;
    k = lookup(c);
    for (int i = 0; i < 2; i++) begin
      m_cerr[i] = 0;
      m_serr[i] = 0;
      if (e) begin
        if (k < 0) begin
          m_cerr[i] = 1; m_run[i] = 0; m_lock[i] = 0; m_valid[i] = 0;
        end else begin
          m_valid[i] = 1;
          m_idx[i]   = k;
          if (m_lock[i]) begin
            if (k != m_exp[i]) begin
              m_serr[i] = 1; m_lock[i] = 0; m_run[i] = 1;
            end
          end else begin
            if (k == m_exp[i] && m_run[i] > 0) m_run[i] = m_run[i] + 1;
            else                               m_run[i] = 1;
            if (m_run[i] >= lock_need[i]) m_lock[i] = 1;
          end
          m_exp[i] = (k + 1) % 8;
        end
      end
      if (clr) m_err[i] = (m_cerr[i] || m_serr[i]) ? 1 : 0;
      else if ((m_cerr[i] || m_serr[i]) && m_err[i] < err_max[i]) m_err[i] = m_err[i] + 1;
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got idx=%0d v=%0b lk=%0b ce=%0b se=%0b err=%0d, expected idx=%0d v=%0b lk=%0b ce=%0b se=%0b err=%0d",
               name, $time, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
               expv[14:12], expv[11], expv[10], expv[9], expv[8], expv[7:0]);
    end
  endtask

  function automatic logic [W-1:0] act0();
    return {idx0, idx_valid0, locked0, code_err0, seq_err0, err_cnt0};
  endfunction

  function automatic logic [W-1:0] act1();
    return {idx1, idx_valid1, locked1, code_err1, seq_err1, 6'd0, err_cnt1};
  endfunction

  // Monitor: every sampling edge produces exactly one registered response.
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) check_vec("inst0_resp", act0(), exp_q0.pop_front());
    if (exp_q1.size() > 0) check_vec("inst1_resp", act1(), exp_q1.pop_front());
    if (code_err0 && seq_err0) begin
      checks++; failures++;
      $display("FAIL inst0_both_pulses at %0t: got both=1, expected at most one", $time);
    end
  end

  task automatic drive(input logic e, input logic [3:0] c, input logic clr);
    @(negedge clk);
    en = e; code = c; clr_err = clr;
    model_step(e, c, clr);
    exp_q0.push_back(pack_model(0));
    exp_q1.push_back(pack_model(1));
  endtask

  task automatic async_reset();
    @(negedge clk);
    en = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_vec("inst0_async_reset", act0(), '0);
    check_vec("inst1_async_reset", act1(), '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cur, r;
    logic e, clr;
    logic [3:0] c;
    reset = 1'b0; en = 1'b0; code = 4'b0000; clr_err = 1'b0;
    model_reset();
    #3;
    check_vec("inst0_reset", act0(), '0);
    check_vec("inst1_reset", act1(), '0);
    @(negedge clk);
    reset = 1'b1;

    // Acquire lock and walk through the 7->0 wrap.
    for (int k = 0; k < 10; k++) drive(1'b1, seq_tab[k % 8], 1'b0);
    drive(1'b1, 4'b1100, 1'b0);
    drive(1'b1, 4'b1110, 1'b0);
    // Illegal code while locked at idx 3, then relock.
    drive(1'b1, 4'b1010, 1'b0);
    drive(1'b1, 4'b1100, 1'b0);
    drive(1'b1, 4'b1110, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    drive(1'b1, 4'b0111, 1'b0);
    // Repeated code while locked, then recovery.
    drive(1'b1, 4'b0111, 1'b0);
    for (int k = 6; k < 12; k++) drive(1'b1, seq_tab[k % 8], 1'b0);
    // Error counter saturation and clear interplay.
    for (int k = 0; k < 5; k++) drive(1'b1, bad_tab[k], 1'b0);
    drive(1'b1, 4'b1101, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    // Enable gaps over a legal stream.
    for (int k = 0; k < 20; k++) drive(k[0] == 1'b0, seq_tab[(k / 2 + 1) % 8], 1'b0);
    async_reset();

    cur = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      cur = (cur + 1) % 8;
      else if (r < 86) cur = (r < 78) ? cur : $urandom_range(0, 7);
      c = seq_tab[cur];
      if (r >= 86 && r < 94) c = bad_tab[$urandom_range(0, 7)];
      else if (r >= 94)      c = 4'($urandom_range(0, 15));
      e   = ($urandom_range(0, 3) != 0);
      clr = e && ($urandom_range(0, 24) == 0);
      drive(e, c, clr);
      if (n == 300) async_reset();
    end

    @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 2: number of consecutive in-sequence legal samples required to enter LOCKED (range 1..7).
REQ-002 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is synchronous to clk.
REQ-005 en  input  1  sample qualifier; code is evaluated only on edges where en=1.
REQ-006 code  input  4  observed 4-bit Johnson counter value.
REQ-007 clr_err  input  1  synchronous clear of err_cnt.
REQ-008 idx  output  3  decoded count index of the last sampled legal code.
REQ-009 idx_valid  output  1  last sample was a legal code.
REQ-010 locked  output  1  FSM is in LOCKED.
REQ-011 code_err  output  1  one-cycle pulse: last sample was an illegal code.
REQ-012 seq_err  output  1  one-cycle pulse: legal but out-of-sequence sample while LOCKED.
REQ-013 err_cnt  output  ERR_W  saturating count of code_err plus seq_err events.

Function
REQ-014 Legal sequence, idx 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001; the next value after 0001 is 0000 (idx wrap 7->0 is in-sequence).
REQ-015 All other 8 codes are illegal; on an illegal sample, idx holds its previous value and idx_valid=0.
REQ-016 Every output is registered; the response to a sample appears exactly 1 cycle after the sampling edge.
REQ-017 en=0: idx, idx_valid, FSM state, expected value, and err_cnt all hold; code_err and seq_err are 0.
REQ-018 The block keeps an internal expected index exp = (idx of the last legal sample + 1) mod 8 and a run counter run (0..LOCK_CNT).
REQ-019 FSM states: HUNT and LOCKED; locked=1 if and only if the state is LOCKED.
REQ-020 HUNT, legal sample with idx==exp and run>0: run+1; when run+1 reaches LOCK_CNT, the FSM moves to LOCKED on the same edge.
REQ-021 HUNT, legal sample otherwise: run=1, exp reloaded from this sample; no error pulse. With LOCK_CNT=1, any legal sample locks.
REQ-022 HUNT, illegal sample: run=0, code_err=1, seq_err=0.
REQ-023 LOCKED, legal sample with idx==exp: stay in LOCKED, no pulse.
REQ-024 LOCKED, legal sample with idx!=exp (including a repeated code): seq_err=1, FSM goes to HUNT, run=1, exp reloaded from this sample.
REQ-025 LOCKED, illegal sample: code_err=1, FSM goes to HUNT, run=0.
REQ-026 code_err and seq_err are never both 1 in the same cycle.
REQ-027 err_cnt increments by 1 per error pulse and saturates at 2^ERR_W-1 with no wrap.
REQ-028 clr_err=1 with no error on the same edge: err_cnt=0. clr_err=1 with an error on the same edge: err_cnt=1.

Reset
REQ-029 On reset=0: state=HUNT, run=0, exp=0, idx=0, idx_valid=0, locked=0, code_err=0, seq_err=0, err_cnt=0.
REQ-030 Reset asserted mid-operation discards lock status and error history immediately, without waiting for a clock edge.

Verification
REQ-031 Reset, then en=1 with code stepping 0000,1000,1100 on each cycle -> idx 0,1,2 with 1-cycle latency; locked rises 1 cycle after the 1000 sample; no error pulses.
REQ-032 Locked stream 0011,0001,0000,1000 -> idx 6,7,0,1; the 7->0 wrap raises no error and locked stays 1.
REQ-033 Locked at idx 3, then 1010 is sampled -> code_err pulse for 1 cycle, idx_valid=0, idx holds 3, locked=0, err_cnt+1; 1100,1110 follow -> relock with no further errors.
REQ-034 Locked, then 1110 is sampled twice in a row -> seq_err on the second sample, locked=0, err_cnt+1; relock occurs after LOCK_CNT in-sequence samples.
REQ-035 ERR_W=2: 5 illegal samples -> err_cnt reads 1,2,3,3,3; clr_err together with a 6th error -> err_cnt=1; clr_err alone -> err_cnt=0.
REQ-036 en toggling 1/0 on alternate cycles over a legal stream -> lock and idx are unaffected by the gaps; reset=0 asserted between clock edges -> all outputs reach their reset values before the next edge.
